// File: rtl/approx_error_monitor.sv
// Measures the error statistics of an approximate adder over a fixed batch of samples.
// A two-stage pipeline computes the error distance, then accumulates count, sum and maximum.
module approx_error_monitor #(
    parameter int N     = 16,
    parameter int BATCH = 256
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              start_i,
    input  logic [N-1:0]                      x_i,
    input  logic [N-1:0]                      y_i,
    input  logic [N:0]                        approx_sum_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [$clog2(BATCH):0]            err_count_o,
    output logic [N+$clog2(BATCH):0]          ed_sum_o,
    output logic [N:0]                        ed_max_o
);

    // state   | meaning
    // S_IDLE  | waiting for start, outputs hold
    // S_RUN   | accepting samples until BATCH have been taken
    // S_DRAIN | two cycles letting the pipeline empty
    // S_DONE  | results stable, waiting for the next start

    localparam int CW = $clog2(BATCH) + 1;
    localparam int SW = N + 1 + $clog2(BATCH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drain_q, drain_d;
    logic            clear;
    logic            accept;
    logic [N:0]      exact;
    logic [N:0]      ed;

    logic            v1_q;
    logic [N:0]      ed1_q;
    logic            err1_q;

    logic [CW-1:0]   err_count_q;
    logic [SW-1:0]   ed_sum_q;
    logic [N:0]      ed_max_q;

    assign in_ready_o = (state_q == S_RUN) && (cnt_q < CW'(BATCH));
    assign accept     = in_valid_i && in_ready_o;
    assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o     = (state_q == S_DONE);

    assign exact = {1'b0, x_i} + {1'b0, y_i};
    assign ed    = (exact >= approx_sum_i) ? (exact - approx_sum_i) : (approx_sum_i - exact);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        clear   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BATCH - 1)) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // down-counter: 1 -> 0 -> leave, giving exactly two drain cycles
                if (drain_q == 1'b0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1_q   <= 1'b0;
            ed1_q  <= '0;
            err1_q <= 1'b0;
        end else begin
            v1_q <= accept && !clear;
            if (accept) begin
                ed1_q  <= ed;
                err1_q <= |ed;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_count_q <= '0;
            ed_sum_q    <= '0;
            ed_max_q    <= '0;
        end else if (clear) begin
            err_count_q <= '0;
            ed_sum_q    <= '0;
            ed_max_q    <= '0;
        end else if (v1_q) begin
            err_count_q <= err_count_q + CW'(err1_q);
            ed_sum_q    <= ed_sum_q + SW'(ed1_q);
            if (ed1_q > ed_max_q) begin
                ed_max_q <= ed1_q;
            end
        end
    end

    assign err_count_o = err_count_q;
    assign ed_sum_o    = ed_sum_q;
    assign ed_max_o    = ed_max_q;

endmodule

// File: doc/approx_error_monitor.md
APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 Parameter N, default 16: operand width of the upstream approximate adder.
REQ-002 Parameter BATCH, default 256: number of samples per measurement run, range 2..65536.
REQ-003 Local widths: CW = $clog2(BATCH)+1; SW = N+1+$clog2(BATCH).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle pulse that begins a run.
REQ-008 x, y  input  N each  operands presented to the upstream adder.
REQ-009 approx_sum  input  N+1  adder result for x, y.
REQ-010 in_valid  input  1  x, y and approx_sum are valid.
REQ-011 in_ready  output  1  block accepts a sample this cycle.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  high in DONE; results are stable.
REQ-014 err_count  output  CW  number of samples with approx_sum != x+y.
REQ-015 ed_sum  output  SW  sum of error distances |(x+y) - approx_sum|.
REQ-016 ed_max  output  N+1  largest error distance in the run.

Function
REQ-017 FSM states:
- IDLE: start -> RUN.
- RUN: the accept that makes the accepted count reach BATCH -> DRAIN.
- DRAIN: fixed 2 cycles -> DONE.
- DONE: start -> RUN.
REQ-018 On the start edge, clear err_count, ed_sum, ed_max, the accepted count and the pipeline valids, and deassert done.
REQ-019 start is ignored in RUN and DRAIN.
REQ-020 in_ready = (state == RUN) and (accepted count < BATCH), combinational from registered state only.
REQ-021 A sample is accepted when in_valid and in_ready are both high in the same cycle; the sample count increments by one.
REQ-022 Stage 1 (register on accept):
- exact = x + y, N+1 bits, no truncation;
- ed = |exact - approx_sum|, N+1 bits unsigned;
- err = (ed != 0);
- v1 = accept.
REQ-023 Stage 2 (when v1):
- ed_sum += ed;
- err_count += err;
- ed_max = max(ed_max, ed).
REQ-024 Accumulators never overflow by construction of the widths; no saturation logic.
REQ-025 Latency: a sample accepted at cycle t is reflected in the outputs at the end of cycle t+2.
REQ-026 done rises exactly 3 cycles after the final accept.
REQ-027 Outputs update only while samples are in flight. They hold in IDLE and DONE until the next start.
REQ-028 Gaps in in_valid (bubbles) are allowed; only accepted samples count.
REQ-029 in_valid while in_ready is low has no effect.

Reset
REQ-030 rst_n low forces IDLE and clears all outputs, counters and pipeline valids to 0 immediately, independent of clk.
REQ-031 Reset mid-run discards all in-flight samples; the first post-reset cycle is IDLE with in_ready=0.
REQ-032 Release of rst_n takes effect on the next rising clk; no run starts without a start pulse.

Verification
REQ-033 Exact samples: N=16, BATCH=4; start; 4 samples, each approx_sum = x+y (e.g. 0x1234+0x0001 -> 0x01235). Required: done after 3 cycles, err_count=0, ed_sum=0, ed_max=0.
REQ-034 Mixed errors: BATCH=4; samples (x, y, approx_sum) =
- (0x0001, 0x0001, 0x000FF): ed 253;
- (0x0300, 0x0100, 0x00400): ed 0;
- (0xFFFF, 0x0001, 0x0FFFF): ed 1;
- (0x0000, 0x0000, 0x00003): ed 3.
Required: err_count=3, ed_sum=257, ed_max=253.
REQ-035 Bubbles and backpressure: in_valid toggling every other cycle, plus in_valid held high after the 4th accept. Required: exactly 4 accepts; in_ready=0 from the cycle after the final accept; results match REQ-034.
REQ-036 Worst case: BATCH=256; every sample x=y=0xFFFF with approx_sum=0 (ed 0x1FFFE). Required: ed_sum = 256*0x1FFFE = 0x1FFFE00 with no wrap; err_count=256.
REQ-037 Reset and restart:
- rst_n low after the 2nd accept -> all outputs 0, state IDLE at once;
- start pulse in RUN -> no clear, run unaffected;
- start in DONE -> outputs cleared and a new run begins.
